mem_access_ctrl: RTL and testbench

- Multi-cycle load/store unit between the MIPS CPU datapath and the 1 KB byte-addressed data memory (dm_1k).
- The memory supports only whole-word little-endian reads (combinational) and writes (posedge).
- This block adds byte and halfword loads/stores (lb/lbu/lh/lhu/sb/sh/lw/sw), sign/zero extension, read-modify-write for sub-word stores, and alignment/range error reporting.
- The CPU uses a valid/ready request and a one-cycle response pulse.

---
 rtl/mem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Multi-cycle byte/half/word load-store unit in front of a word-only data memory.
// Define MEM_ACCESS_CTRL_ALIGN_CHECK_EN to report misaligned, out-of-range and reserved-size requests.
module mem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic [31:0]           dm_din,
  output logic                  dm_we,
  input  logic [31:0]           dm_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  signed_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;

  logic [1:0]            acc_size_d;
  logic [ADDR_WIDTH-1:0] acc_addr_d;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
  logic acc_err_d;
  logic resp_err_q;

  always_comb begin
    acc_size_d = req_size;
    acc_addr_d = req_addr[ADDR_WIDTH-1:0];
    acc_err_d  = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (|req_addr[31:ADDR_WIDTH]);
  end

  assign resp_err = resp_err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  // Without checking, reserved size acts as word and the address is aligned down and wrapped.
  always_comb begin
    acc_size_d = (req_size == 2'b11) ? 2'b10 : req_size;
    acc_addr_d = req_addr[ADDR_WIDTH-1:0];
    if (acc_size_d == 2'b01)      acc_addr_d[0]   = 1'b0;
    else if (acc_size_d == 2'b10) acc_addr_d[1:0] = 2'b00;
  end

  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= acc_addr_d;
            wdata_q  <= req_wdata;
            size_q   <= acc_size_d;
            we_q     <= req_we;
            signed_q <= req_signed;
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
            if (acc_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we && acc_size_d == 2'b10) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ;
            end
`else
            if (req_we && acc_size_d == 2'b10) state_q <= WRITE;
            else                               state_q <= READ;
`endif
          end
        end
        READ: begin
          buf_q <= dm_dout;
          if (we_q) begin
            state_q <= WRITE;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_extract(dm_dout, addr_q[1:0], size_q, signed_q);
          end
        end
        WRITE: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write strobe is gated by rst so a reset landing on WRITE never reaches memory.
  always_comb begin
    dm_addr = '0;
    dm_din  = '0;
    dm_we   = 1'b0;
    if (state_q == READ || state_q == WRITE) dm_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    if (state_q == WRITE) begin
      dm_we  = !rst;
      dm_din = store_merge(buf_q, wdata_q, addr_q[1:0], size_q);
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: word memory model plus a byte-array reference model.
// Follows MEM_ACCESS_CTRL_ALIGN_CHECK_EN the same way the design does.
module tb_mem_access_ctrl;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din, dm_dout;
  logic          dm_we;

  logic [31:0] mem_w  [256];
  logic [31:0] init_w [256];
  logic        mem_init;
  logic [7:0]  ref_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  assign dm_dout = mem_w[dm_addr[AW-1:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_w[i] <= init_w[i];
    end else if (dm_we) begin
      mem_w[dm_addr[AW-1:2]] <= dm_din;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_word(input int unsigned a);
    int unsigned b;
    b = a - (a % 4);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // Byte-array view of the access: computes the outcome and applies stores.
  task automatic model_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic exp_err, output logic [31:0] exp_rd,
                              output int exp_lat, output int exp_nwe, output int unsigned eff);
    int unsigned nb, ea;
    logic [1:0]  s;
    logic [31:0] v;
    exp_rd = '0;
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
    s       = sz;
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 32'd1024);
    ea      = a;
`else
    s       = (sz == 2'd3) ? 2'd2 : sz;
    exp_err = 1'b0;
    ea      = a % 1024;
`endif
    nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    ea = ea - (ea % nb);
    eff = ea;
    if (exp_err) begin
      exp_lat = 1; exp_nwe = 0; eff = 0;
    end else if (we) begin
      for (int i = 0; i < int'(nb); i++) ref_mem[ea+i] = wd[8*i +: 8];
      exp_lat = (nb == 4) ? 2 : 3;
      exp_nwe = 1;
    end else begin
      v = 0;
      for (int i = 0; i < int'(nb); i++) v = v + (32'(ref_mem[ea+i]) << (8*i));
      if (sg && nb == 1 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
      if (sg && nb == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      exp_rd = v; exp_lat = 2; exp_nwe = 0;
    end
  endtask

  // Drives one request from an IDLE-aligned point (#1 after posedge) and observes the result.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nwe, output logic tail_ok);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nwe = 0; rd = '0; er = 1'b0; tail_ok = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (dm_we) nwe++;
      if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; break; end
      @(posedge clk); #1;
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      tail_ok = !resp_valid && req_ready;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      init_w[i] = $urandom();
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = init_w[i][8*k +: 8];
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_init = 1'b0;
    n_checks++; if (req_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_err !== 1'b0)      begin n_fail++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    n_checks++; if (resp_rdata !== 32'h0)   begin n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    n_checks++; if (dm_we !== 1'b0)         begin n_fail++; $display("FAIL reset_dm_we: got %b expected 0", dm_we); end
    n_checks++; if (dm_addr !== '0)         begin n_fail++; $display("FAIL reset_dm_addr: got %h expected 0", dm_addr); end
    n_checks++; if (dm_din !== 32'h0)       begin n_fail++; $display("FAIL reset_dm_din: got %h expected 0", dm_din); end
  endtask

  task automatic test_basic();
    logic        t_we  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_sz  [8] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    logic        t_sg  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_a   [8] = '{32'h4, 32'h4, 32'h5, 32'h5, 32'h5, 32'h6, 32'h6, 32'h4};
    logic [31:0] t_wd  [8] = '{32'hDEADBEEF, 32'h0, 32'h000000AA, 32'h0, 32'h0, 32'h00001234, 32'h0, 32'h0};
    logic [31:0] t_exp [8] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADAAEF, 32'hFFFFFFAA,
                               32'h000000AA, 32'h1234AAEF, 32'h00001234, 32'hFFFFAAEF};
    logic [31:0] rd, e_rd;
    logic        er, e_er, tail;
    int          lat, nwe, e_lat, e_nwe;
    int unsigned eff;
    for (int i = 0; i < 8; i++) begin
      do_req(t_we[i], t_sz[i], t_sg[i], t_a[i], t_wd[i], rd, er, lat, nwe, tail);
      model_access(t_we[i], t_sz[i], t_sg[i], t_a[i], t_wd[i], e_er, e_rd, e_lat, e_nwe, eff);
      n_checks++; if (er !== 1'b0)   begin n_fail++; $display("FAIL basic[%0d]_err: got %b expected 0", i, er); end
      n_checks++; if (lat != e_lat)  begin n_fail++; $display("FAIL basic[%0d]_latency: got %0d expected %0d", i, lat, e_lat); end
      n_checks++; if (nwe != e_nwe)  begin n_fail++; $display("FAIL basic[%0d]_dm_we_pulses: got %0d expected %0d", i, nwe, e_nwe); end
      n_checks++; if (!tail)         begin n_fail++; $display("FAIL basic[%0d]_single_pulse: got 0 expected 1", i); end
      if (t_we[i]) begin
        n_checks++; if (mem_w[1] !== t_exp[i]) begin n_fail++; $display("FAIL basic[%0d]_mem_word: got %h expected %h", i, mem_w[1], t_exp[i]); end
        n_checks++; if (rd !== 32'h0)          begin n_fail++; $display("FAIL basic[%0d]_store_rdata: got %h expected 0", i, rd); end
      end else begin
        n_checks++; if (rd !== t_exp[i])       begin n_fail++; $display("FAIL basic[%0d]_rdata: got %h expected %h", i, rd, t_exp[i]); end
        n_checks++; if (rd !== e_rd)           begin n_fail++; $display("FAIL basic[%0d]_rdata_model: got %h expected %h", i, rd, e_rd); end
      end
    end
  endtask

  task automatic test_errors();
    logic        t_we [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  t_sz [3] = '{2'd2, 2'd1, 2'd2};
    logic [31:0] t_a  [3] = '{32'h002, 32'h003, 32'h400};
    logic [31:0] rd, e_rd, w0, w1;
    logic        er, e_er, tail;
    int          lat, nwe, e_lat, e_nwe;
    int unsigned eff;
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      w0 = ref_word(0); w1 = ref_word(4);
      do_req(t_we[i], t_sz[i], 1'b0, t_a[i], 32'hA5A5_5A5A, rd, er, lat, nwe, tail);
      model_access(t_we[i], t_sz[i], 1'b0, t_a[i], 32'hA5A5_5A5A, e_er, e_rd, e_lat, e_nwe, eff);
      n_checks++; if (er !== 1'b1)     begin n_fail++; $display("FAIL err[%0d]_resp_err: got %b expected 1", i, er); end
      n_checks++; if (lat != 1)        begin n_fail++; $display("FAIL err[%0d]_latency: got %0d expected 1", i, lat); end
      n_checks++; if (rd !== 32'h0)    begin n_fail++; $display("FAIL err[%0d]_rdata: got %h expected 0", i, rd); end
      n_checks++; if (nwe != 0)        begin n_fail++; $display("FAIL err[%0d]_dm_we_pulses: got %0d expected 0", i, nwe); end
      n_checks++; if (mem_w[0] !== w0) begin n_fail++; $display("FAIL err[%0d]_mem0: got %h expected %h", i, mem_w[0], w0); end
      n_checks++; if (mem_w[1] !== w1) begin n_fail++; $display("FAIL err[%0d]_mem1: got %h expected %h", i, mem_w[1], w1); end
    end
`else
    w0 = ref_word(0);
    do_req(1'b0, 2'd2, 1'b0, 32'h002, 32'h0, rd, er, lat, nwe, tail);
    model_access(1'b0, 2'd2, 1'b0, 32'h002, 32'h0, e_er, e_rd, e_lat, e_nwe, eff);
    n_checks++; if (rd !== w0)   begin n_fail++; $display("FAIL noerr_lw_misaligned: got %h expected %h", rd, w0); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL noerr_resp_err: got %b expected 0", er); end
    n_checks++; if (lat != 2)    begin n_fail++; $display("FAIL noerr_latency: got %0d expected 2", lat); end
    do_req(1'b0, 2'd3, 1'b0, 32'h409, 32'h0, rd, er, lat, nwe, tail);
    model_access(1'b0, 2'd3, 1'b0, 32'h409, 32'h0, e_er, e_rd, e_lat, e_nwe, eff);
    n_checks++; if (rd !== ref_word(8)) begin n_fail++; $display("FAIL noerr_reserved_wrap: got %h expected %h", rd, ref_word(8)); end
    n_checks++; if (lat != 2)           begin n_fail++; $display("FAIL noerr_reserved_latency: got %0d expected 2", lat); end
    n_checks++; if (nwe != 0)           begin n_fail++; $display("FAIL noerr_dm_we_pulses: got %0d expected 0", nwe); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] w1;
    w1 = ref_word(4);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h5; req_wdata = 32'h0000_0077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_write_cycle_dm_we: got %b expected 1", dm_we); end
    rst = 1'b1;
    #1;
    n_checks++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_dm_we_gated: got %b expected 0", dm_we); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL rstmid_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (mem_w[1] !== w1)     begin n_fail++; $display("FAIL rstmid_mem_unchanged: got %h expected %h", mem_w[1], w1); end
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp_valid_after: got %b expected 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2, dummy_rd;
    logic        e_er, acc;
    int          e_lat, e_nwe, nacc;
    int unsigned eff;
    logic [31:0] got[$];
    int          rc[$];
    int          ac[2];
    model_access(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, e_er, e1, e_lat, e_nwe, eff);
    model_access(1'b0, 2'd0, 1'b0, 32'h021, 32'h0, e_er, e2, e_lat, e_nwe, eff);
    dummy_rd = '0; ac[0] = -1; ac[1] = -1; nacc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h010;
    for (int c = 0; c < 12; c++) begin
      acc = req_valid && req_ready;
      if (resp_valid) begin got.push_back(resp_rdata); rc.push_back(c); end
      if (acc && nacc < 2) begin ac[nacc] = c; nacc++; end
      @(posedge clk); #1;
      if (acc) begin
        if (nacc == 1) begin req_size = 2'd0; req_addr = 32'h021; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_checks++; if (ac[0] != 0)       begin n_fail++; $display("FAIL b2b_accept0_cycle: got %0d expected 0", ac[0]); end
    n_checks++; if (ac[1] != 3)       begin n_fail++; $display("FAIL b2b_accept1_cycle: got %0d expected 3", ac[1]); end
    n_checks++; if (got.size() != 2)  begin n_fail++; $display("FAIL b2b_resp_count: got %0d expected 2", got.size()); end
    if (got.size() == 2) begin
      n_checks++; if (rc[0] != 2)     begin n_fail++; $display("FAIL b2b_resp0_cycle: got %0d expected 2", rc[0]); end
      n_checks++; if (rc[1] != 5)     begin n_fail++; $display("FAIL b2b_resp1_cycle: got %0d expected 5", rc[1]); end
      n_checks++; if (got[0] !== e1)  begin n_fail++; $display("FAIL b2b_rdata0: got %h expected %h", got[0], e1); end
      n_checks++; if (got[1] !== e2)  begin n_fail++; $display("FAIL b2b_rdata1: got %h expected %h", got[1], e2); end
    end
    if (dummy_rd !== 32'h0) $display("note: unused");
  endtask

  task automatic test_random();
    logic        we, sg, er, e_er, tail;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd, e_rd;
    int          lat, nwe, e_lat, e_nwe;
    int unsigned eff;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom();
      a  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1 && sz == 2'd1) a[0] = 1'b0;
      if ($urandom_range(0, 1) == 1 && sz == 2'd2) a[1:0] = 2'b00;
      do_req(we, sz, sg, a, wd, rd, er, lat, nwe, tail);
      model_access(we, sz, sg, a, wd, e_er, e_rd, e_lat, e_nwe, eff);
      n_checks++;
      if (rd !== e_rd || er !== e_er || lat != e_lat || nwe != e_nwe || !tail) begin
        n_fail++;
        $display("FAIL rand[%0d] we=%0d sz=%0d sg=%0d a=%h: got rd=%h err=%b lat=%0d we_pulses=%0d tail=%b expected rd=%h err=%b lat=%0d we_pulses=%0d tail=1",
                 i, we, sz, sg, a, rd, er, lat, nwe, tail, e_rd, e_er, e_lat, e_nwe);
      end
      if (we && !e_er) begin
        n_checks++;
        if (mem_w[eff/4] !== ref_word(eff)) begin
          n_fail++;
          $display("FAIL rand[%0d]_mem_word @%h: got %h expected %h", i, eff, mem_w[eff/4], ref_word(eff));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
